// File: rtl/cic_interp_iq_param.sv
// rtl/cic_interp_iq_param.sv - parametrised I/Q CIC interpolator with runtime rate, shift, round and saturate
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous flush of comb/integrator state, phase and ovf
//   rate_i            interpolation rate R (clamped to 2..RMAX, sampled at accept)
//   shift_i           arithmetic right shift applied to the integrator output
//   gain_i            signed Q1.15 gain trim, only used when CIC_GAIN_COMP_EN is defined
//   s_valid/s_ready   input handshake, s_real/s_imag input I/Q pair
//   m_valid/m_ready   output handshake, m_real/m_imag output I/Q pair
//   ovf               sticky saturation flag
// Optional feature macro: CIC_GAIN_COMP_EN (adds a registered Q1.15 gain stage, latency 3 instead of 2)
module cic_interp_iq_param #(
    parameter int DW   = 16,
    parameter int N    = 3,
    parameter int RMAX = 16,
    localparam int RW  = $clog2(RMAX + 1),
    localparam int IW  = DW + N * $clog2(RMAX)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic [RW-1:0]        rate_i,
    input  logic [4:0]           shift_i,
    input  logic signed [15:0]   gain_i,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_real,
    input  logic signed [DW-1:0] s_imag,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic signed [DW-1:0] m_real,
    output logic signed [DW-1:0] m_imag,
    output logic                 ovf
);
    // SW holds a shifted+rounded accumulator (one bit of headroom for the rounding add),
    // PW holds that value times a 16-bit gain before the final saturation.
    localparam int SW = IW + 1;
    localparam int PW = SW + 16;
    localparam logic signed [PW-1:0] SMAX = {{(PW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [PW-1:0] SMIN = {{(PW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    typedef enum logic {IDLE, RUN} state_t;

    state_t                state, state_nxt;
    logic                  live;
    logic [RW-1:0]         rate_q, rate_c, p;
    logic                  stall, accept, adv, last, ld;
    logic signed [IW-1:0]  cd  [2][N];
    logic signed [IW-1:0]  co  [2];
    logic signed [IW-1:0]  ig  [2][N];
    logic signed [IW-1:0]  cs  [2][N+1];
    logic signed [IW-1:0]  ign [2][N];
    logic signed [IW-1:0]  inj [2];
    logic signed [SW-1:0]  shv [2];
    logic signed [PW-1:0]  pre [2];

    // Round half-up then arithmetic shift; computed wide so 2^(sh-1) never overflows.
    function automatic logic signed [SW-1:0] scale(input logic signed [IW-1:0] acc, input logic [4:0] sh);
        logic signed [IW+32:0] ext, rnd;
        ext = {{33{acc[IW-1]}}, acc};
        rnd = (sh == 5'd0) ? '0 : ({{IW{1'b0}}, 33'd1} << (sh - 5'd1));
        return SW'((ext + rnd) >>> sh);
    endfunction

    function automatic logic signed [PW-1:0] widen(input logic signed [SW-1:0] v);
        return {{16{v[SW-1]}}, v};
    endfunction

    function automatic logic oor(input logic signed [PW-1:0] x);
        return (x > SMAX) || (x < SMIN);
    endfunction

    function automatic logic signed [DW-1:0] clip(input logic signed [PW-1:0] x);
        if (x > SMAX) return SMAX[DW-1:0];
        if (x < SMIN) return SMIN[DW-1:0];
        return x[DW-1:0];
    endfunction

    assign stall  = m_valid & ~m_ready;
    assign accept = s_valid & s_ready;

    always_comb begin
        rate_c = rate_i;
        if (rate_i < RW'(2))         rate_c = RW'(2);
        else if (rate_i > RW'(RMAX)) rate_c = RW'(RMAX);
    end

    // Combs at input rate, then the integrator cascade (each stage sees the
    // freshly updated value of the previous one, so there is no per-stage delay).
    always_comb begin
        cs[0][0] = {{(IW-DW){s_real[DW-1]}}, s_real};
        cs[1][0] = {{(IW-DW){s_imag[DW-1]}}, s_imag};
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < N; k++) cs[c][k+1] = cs[c][k] - cd[c][k];
            inj[c]    = (p == '0) ? co[c] : '0;
            ign[c][0] = ig[c][0] + inj[c];
            for (int k = 1; k < N; k++) ign[c][k] = ig[c][k] + ign[c][k-1];
            shv[c] = scale(ign[c][N-1], shift_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        adv       = 1'b0;
        last      = (p == rate_q - RW'(1));
        case (state)
            IDLE: begin
                s_ready = live & ~stall;
                if (s_valid && s_ready) state_nxt = RUN;
            end
            RUN: begin
                adv     = ~stall;
                s_ready = live & ~stall & last;
                if (adv && last && !(s_valid && s_ready)) state_nxt = IDLE;
            end
        endcase
        if (clr) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live   <= 1'b0;
            rate_q <= '0;
            p      <= '0;
            for (int c = 0; c < 2; c++) begin
                co[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    cd[c][k] <= '0;
                    ig[c][k] <= '0;
                end
            end
        end else if (clr) begin
            live <= 1'b1;
            p    <= '0;
            for (int c = 0; c < 2; c++) begin
                co[c] <= '0;
                for (int k = 0; k < N; k++) begin
                    cd[c][k] <= '0;
                    ig[c][k] <= '0;
                end
            end
        end else begin
            live <= 1'b1;
            // accept and adv both already imply no stall
            if (accept) begin
                rate_q <= rate_c;
                p      <= '0;
                for (int c = 0; c < 2; c++) begin
                    co[c] <= cs[c][N];
                    for (int k = 0; k < N; k++) cd[c][k] <= cs[c][k];
                end
            end
            if (adv) begin
                for (int c = 0; c < 2; c++)
                    for (int k = 0; k < N; k++) ig[c][k] <= ign[c][k];
                if (!accept) p <= last ? '0 : p + RW'(1);
            end
        end
    end

`ifdef CIC_GAIN_COMP_EN
    logic                 v1;
    logic signed [SW-1:0] shq [2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1     <= 1'b0;
            shq[0] <= '0;
            shq[1] <= '0;
        end else if (clr) begin
            v1     <= 1'b0;
            shq[0] <= '0;
            shq[1] <= '0;
        end else if (!stall) begin
            v1 <= adv;
            if (adv) begin
                shq[0] <= shv[0];
                shq[1] <= shv[1];
            end
        end
    end

    // Q1.15 multiply, round half-up back to integer scale; saturation follows in the output stage.
    always_comb begin
        for (int c = 0; c < 2; c++)
            pre[c] = ((PW'(shq[c]) * PW'(gain_i)) + PW'(16384)) >>> 15;
    end
    assign ld = v1;
`else
    logic unused_gain;
    assign unused_gain = ^gain_i;

    always_comb begin
        for (int c = 0; c < 2; c++) pre[c] = widen(shv[c]);
    end
    assign ld = adv;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
            ovf     <= 1'b0;
        end else if (clr) begin
            m_valid <= 1'b0;
            m_real  <= '0;
            m_imag  <= '0;
            ovf     <= 1'b0;
        end else if (!stall) begin
            m_valid <= ld;
            if (ld) begin
                m_real <= clip(pre[0]);
                m_imag <= clip(pre[1]);
                ovf    <= ovf | oor(pre[0]) | oor(pre[1]);
            end
        end
    end
endmodule

// File: tb/tb_cic_interp_iq_param.sv
// tb/tb_cic_interp_iq_param.sv - directed self-checking bench for cic_interp_iq_param
module tb_cic_interp_iq_param;
    localparam int DW = 16;
    localparam int N = 3;
    localparam int RMAX = 16;
    localparam int RW = $clog2(RMAX + 1);
`ifdef CIC_GAIN_COMP_EN
    localparam int LAT = 3;
    localparam int DC_RE = 391;
    localparam int DC_IM = -390;
    localparam int DC0_RE = 4;
    localparam int DC0_IM = -4;
`else
    localparam int LAT = 2;
    localparam int DC_RE = 781;
    localparam int DC_IM = -781;
    localparam int DC0_RE = 8;
    localparam int DC0_IM = -8;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 clr = 1'b0;
    logic [RW-1:0]        rate_i = 5'd10;
    logic [4:0]           shift_i = 5'd7;
    logic signed [15:0]   gain_i = 16'sh4000;
    logic                 s_valid = 1'b0;
    logic                 s_ready;
    logic signed [DW-1:0] s_real = '0;
    logic signed [DW-1:0] s_imag = '0;
    logic                 m_valid;
    logic                 m_ready = 1'b1;
    logic signed [DW-1:0] m_real;
    logic signed [DW-1:0] m_imag;
    logic                 ovf;

    cic_interp_iq_param #(.DW(DW), .N(N), .RMAX(RMAX)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .rate_i(rate_i), .shift_i(shift_i),
        .gain_i(gain_i), .s_valid(s_valid), .s_ready(s_ready), .s_real(s_real),
        .s_imag(s_imag), .m_valid(m_valid), .m_ready(m_ready), .m_real(m_real),
        .m_imag(m_imag), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int in_re[$], in_im[$], out_re[$], out_im[$], acc_cyc[$], dc_re[$], dc_im[$];
    int cyc = 0;
    int first_out = -1;
    int stall_rdy = 0;
    int mr_mode = 0;
    int mr_ph = 0;
    int imp[10] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1};

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive from the stimulus queue, log handshakes, step to 1 time unit past the edge.
    task automatic tick();
        if (mr_mode != 0) begin
            m_ready = (mr_ph % 3 == 0);
            mr_ph++;
        end else begin
            m_ready = 1'b1;
        end
        s_valid = (in_re.size() > 0);
        s_real  = s_valid ? 16'(in_re[0]) : '0;
        s_imag  = s_valid ? 16'(in_im[0]) : '0;
        #1;
        if (s_valid && s_ready) begin
            void'(in_re.pop_front());
            void'(in_im.pop_front());
            acc_cyc.push_back(cyc);
        end
        if (m_valid && m_ready) begin
            out_re.push_back(int'(m_real));
            out_im.push_back(int'(m_imag));
            if (first_out < 0) first_out = cyc;
        end
        if (m_valid && !m_ready && s_ready) stall_rdy++;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_until(input int nout, input int budget);
        int b = budget;
        while (out_re.size() < nout && b > 0) begin
            tick();
            b--;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic clear_all();
        clr = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        out_re.delete(); out_im.delete(); acc_cyc.delete();
        in_re.delete(); in_im.delete();
        first_out = -1; cyc = 0; stall_rdy = 0;
    endtask

    task automatic push(input int re, input int im, input int n);
        for (int i = 0; i < n; i++) begin
            in_re.push_back(re);
            in_im.push_back(im);
        end
    endtask

    initial begin
        int bad;
        int sum;
        // reset with s_valid held high
        s_valid = 1'b1;
        s_real = 16'sd1234;
        #12;
        check("rst_s_ready", int'(s_ready), 0);
        check("rst_m_valid", int'(m_valid), 0);
        check("rst_m_real", int'(m_real), 0);
        check("rst_m_imag", int'(m_imag), 0);
        check("rst_ovf", int'(ovf), 0);
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_s_ready", int'(s_ready), 1);

        // impulse, R=4, shift 0
        rate_i = 5'd4; shift_i = 5'd0; gain_i = 16'sh7FFF;
        clear_all();
        push(1, -2, 1);
        push(0, 0, 4);
        run_until(20, 100);
        run(6);
        check("imp_count", out_re.size(), 20);
        check("imp_latency", (acc_cyc.size() > 0) ? first_out - acc_cyc[0] : -1, LAT);
        sum = 0;
        for (int i = 0; i < 20 && i < out_re.size(); i++) begin
            check($sformatf("imp_re[%0d]", i), out_re[i], (i < 10) ? imp[i] : 0);
            check($sformatf("imp_im[%0d]", i), out_im[i], (i < 10) ? -2 * imp[i] : 0);
            sum += out_re[i];
        end
        check("imp_sum", sum, 64);

        // DC, R=10, shift 7
        rate_i = 5'd10; shift_i = 5'd7; gain_i = 16'sh4000;
        clear_all();
        push(1000, -1000, 30);
        run_until(300, 1000);
        check("dc_count", out_re.size(), 300);
        check("dc_accepts", acc_cyc.size(), 30);
        check("dc_latency", (acc_cyc.size() > 0) ? first_out - acc_cyc[0] : -1, LAT);
        check("dc_gap", (acc_cyc.size() > 1) ? acc_cyc[1] - acc_cyc[0] : -1, 10);
        if (out_re.size() == 300) begin
            check("dc_first_re", out_re[0], DC0_RE);
            check("dc_first_im", out_im[0], DC0_IM);
            check("dc_last_re", out_re[299], DC_RE);
            check("dc_last_im", out_im[299], DC_IM);
            bad = 0;
            for (int i = 40; i < 300; i++)
                if (out_re[i] != DC_RE || out_im[i] != DC_IM) bad++;
            check("dc_steady_bad", bad, 0);
        end
        dc_re = out_re;
        dc_im = out_im;

        // backpressure: m_ready pattern 1,0,0,...
        clear_all();
        mr_mode = 1; mr_ph = 0;
        push(1000, -1000, 30);
        run_until(300, 3000);
        mr_mode = 0;
        check("bp_count", out_re.size(), 300);
        bad = 0;
        for (int i = 0; i < 300 && i < out_re.size() && i < dc_re.size(); i++)
            if (out_re[i] != dc_re[i] || out_im[i] != dc_im[i]) bad++;
        check("bp_diff", bad, 0);
        check("bp_ready_in_stall", stall_rdy, 0);

        // saturation, R=16, shift 0
        rate_i = 5'd16; shift_i = 5'd0; gain_i = 16'sh7FFF;
        clear_all();
        check("sat_ovf_pre", int'(ovf), 0);
        push(32767, -32768, 10);
        run_until(160, 400);
        check("sat_count", out_re.size(), 160);
        if (out_re.size() == 160) begin
            check("sat_re", out_re[159], 32767);
            check("sat_im", out_im[159], -32768);
        end
        check("sat_ovf", int'(ovf), 1);
        run(5);
        check("sat_ovf_sticky", int'(ovf), 1);
        clear_all();
        check("clr_ovf", int'(ovf), 0);
        check("clr_m_valid", int'(m_valid), 0);
        push(1, -2, 1);
        run_until(1, 20);
        check("clr_state_re", (out_re.size() > 0) ? out_re[0] : -99, 1);
        check("clr_state_im", (out_im.size() > 0) ? out_im[0] : -99, -2);

        // rate clamping
        rate_i = 5'd1;
        clear_all();
        push(0, 0, 2);
        run(20);
        check("clamp_lo_count", out_re.size(), 4);
        rate_i = 5'd31;
        clear_all();
        push(0, 0, 1);
        run(30);
        check("clamp_hi_count", out_re.size(), 16);

        // rate change mid-burst
        rate_i = 5'd10; shift_i = 5'd7; gain_i = 16'sh4000;
        clear_all();
        push(1000, -1000, 3);
        tick();
        rate_i = 5'd5;
        run(60);
        check("rc_count", out_re.size(), 20);
        check("rc_gap1", (acc_cyc.size() > 2) ? acc_cyc[1] - acc_cyc[0] : -1, 10);
        check("rc_gap2", (acc_cyc.size() > 2) ? acc_cyc[2] - acc_cyc[1] : -1, 5);

        // clr together with an accept drops the input
        clear_all();
        s_valid = 1'b1; s_real = 16'sd100; s_imag = 16'sd100; clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0; s_valid = 1'b0;
        run(10);
        check("clr_accept_outputs", out_re.size(), 0);

        // reset mid-burst
        rate_i = 5'd4; shift_i = 5'd0;
        clear_all();
        push(500, 500, 5);
        run(6);
        rst_n = 1'b0;
        #1;
        check("rst_mid_m_valid", int'(m_valid), 0);
        check("rst_mid_s_ready", int'(s_ready), 0);
        check("rst_mid_m_real", int'(m_real), 0);
        in_re.delete(); in_im.delete(); out_re.delete(); out_im.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_rel_ready", int'(s_ready), 1);
        run(10);
        check("rst_mid_no_resume", out_re.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
